// File: rtl/product_acc_pkg.sv
// Shared widths, state encoding and helpers for the product accumulator MAC back end.
package product_acc_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;

  // Clamp limits at the default accumulator width.
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational sign-extend + add with overflow flag and optional clamp.
module sat_add #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic [OUT_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [OUT_W-1:0] sum,
  output logic             ovf
);

  logic [OUT_W:0] wide;

  assign wide = {a[OUT_W-1], a} + {{(OUT_W+1-IN_W){b[IN_W-1]}}, b};
  assign ovf  = wide[OUT_W] ^ wide[OUT_W-1];

  always_comb begin
    sum = wide[OUT_W-1:0];
    if (SATURATE && ovf)
      sum = wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of signed products into blocks and emits one registered
// dot-product result per block (BLOCK_LEN products or earlier on prod_last).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = 16,
  parameter bit SATURATE  = 1'b1,
  localparam int CNT_W    = clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic              clear,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_sat
);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_base, sum;
  logic [CNT_W-1:0]   cnt, cnt_base, cnt_inc;
  logic               sat_sticky, sat_base, ovf;
  logic               xfer_in, xfer_out, done;

  // FLUSH means a result sits in the output register awaiting acc_ready.
  assign acc_valid  = (state == FLUSH);
  assign prod_ready = ~acc_valid | acc_ready;
  assign xfer_in    = prod_valid & prod_ready;
  assign xfer_out   = acc_valid & acc_ready;

  // clear folds into the base so a same-cycle product opens the new block.
  assign acc_base = clear ? '0 : acc;
  assign cnt_base = clear ? '0 : cnt;
  assign sat_base = clear ? 1'b0 : sat_sticky;
  assign cnt_inc  = cnt_base + 1'b1;
  assign done     = xfer_in & (prod_last | (cnt_inc == CNT_W'(BLOCK_LEN)));

  sat_add #(.IN_W(PROD_W), .OUT_W(ACC_W), .SATURATE(SATURATE)) u_add (
    .a   (acc_base),
    .b   (prod_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_nxt = state;
    if (done)          state_nxt = FLUSH;
    else if (xfer_out) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      acc_data   <= '0;
      acc_count  <= '0;
      acc_sat    <= 1'b0;
    end else if (done) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      acc_data   <= sum;
      acc_count  <= cnt_inc;
      acc_sat    <= sat_base | ovf;
    end else if (xfer_in) begin
      acc        <= sum;
      cnt        <= cnt_inc;
      sat_sticky <= sat_base | ovf;
    end else if (clear) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
    end
  end

endmodule
